// File: rtl/flex_mode_counter.sv
// flex_mode_counter: up/down counter with a programmable terminal value and
// three counting modes (WRAP, SATURATE, ONESHOT). The count, the rollover
// flag and the done flag all come straight from flops.
module flex_mode_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    load,
  input  logic [NUM_CNT_BITS-1:0] load_val,
  input  logic                    count_enable,
  input  logic                    up_down,
  input  logic [1:0]              mode,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag,
  output logic                    done
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic [1:0] MODE_WRAP     = 2'b00;
  localparam logic [1:0] MODE_SATURATE = 2'b01;
  localparam logic [1:0] MODE_ONESHOT  = 2'b10;

  localparam logic [NUM_CNT_BITS-1:0] ONE  = NUM_CNT_BITS'(1);
  localparam logic [NUM_CNT_BITS-1:0] ZERO = '0;

  state_t                  state, next_state;
  logic [NUM_CNT_BITS-1:0] count_q, next_count;
  logic                    flag_q, done_q;
  logic [NUM_CNT_BITS-1:0] count_inc, count_dec;

  assign count_inc = count_q + ONE;
  assign count_dec = count_q - ONE;

  // Register the count, the oneshot state and both flags; the flags are
  // derived from next-state values so they line up with count_out.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= IDLE;
      count_q <= '0;
      flag_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= next_state;
      count_q <= next_count;
      flag_q  <= (next_count == rollover_val);
      done_q  <= (next_state == DONE);
    end
  end

  // Next count and oneshot state: clear beats load beats counting beats hold.
  // A terminal value of zero disables counting entirely, and any mode other
  // than ONESHOT parks the state machine in IDLE.
  always_comb begin
    next_count = count_q;
    next_state = state;
    if (clear) begin
      next_count = '0;
      next_state = IDLE;
    end else if (load) begin
      next_count = load_val;
      next_state = IDLE;
    end else if (mode != MODE_ONESHOT) begin
      next_state = IDLE;
      if (count_enable && (rollover_val != ZERO)) begin
        if (mode == MODE_SATURATE) begin
          if (up_down) begin
            next_count = (count_q >= rollover_val) ? rollover_val : count_inc;
          end else begin
            next_count = (count_q > ZERO) ? count_dec : ZERO;
          end
        end else begin
          if (up_down) begin
            next_count = (count_q >= rollover_val) ? ONE : count_inc;
          end else begin
            next_count = (count_q > ONE) ? count_dec : rollover_val;
          end
        end
      end
    end else if (count_enable && (rollover_val != ZERO) && (state != DONE)) begin
      if (count_q >= rollover_val) begin
        next_count = rollover_val;
        next_state = DONE;
      end else begin
        next_count = count_inc;
        next_state = (count_inc == rollover_val) ? DONE : RUN;
      end
    end
  end

  assign count_out     = count_q;
  assign rollover_flag = flag_q;
  assign done          = done_q;

endmodule

// File: tb/tb_flex_mode_counter.sv
// Directed testbench for flex_mode_counter: walks through each counting mode,
// the input priority, the oneshot state machine and asynchronous reset.
module tb_flex_mode_counter;

  logic       clk;
  logic       n_rst;
  logic       clear;
  logic       load;
  logic [3:0] load_val;
  logic       count_enable;
  logic       up_down;
  logic [1:0] mode;
  logic [3:0] rollover_val;
  logic [3:0] count_out;
  logic       rollover_flag;
  logic       done;

  int tests_run = 0;
  int tests_failed = 0;

  flex_mode_counter #(.NUM_CNT_BITS(4)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (clear),
    .load         (load),
    .load_val     (load_val),
    .count_enable (count_enable),
    .up_down      (up_down),
    .mode         (mode),
    .rollover_val (rollover_val),
    .count_out    (count_out),
    .rollover_flag(rollover_flag),
    .done         (done)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and settle just after it.
  task automatic apply_stimulus();
    @(posedge clk);
    #1;
  endtask

  // Compare all three outputs against hand-computed values.
  task automatic check_output(input string tag, input logic [3:0] exp_count,
                              input logic exp_flag, input logic exp_done);
    tests_run++;
    assert (count_out === exp_count) else begin
      tests_failed++;
      $error("[TB] FAIL %s count_out got %0d expected %0d", tag, count_out, exp_count);
    end
    tests_run++;
    assert (rollover_flag === exp_flag) else begin
      tests_failed++;
      $error("[TB] FAIL %s rollover_flag got %b expected %b", tag, rollover_flag, exp_flag);
    end
    tests_run++;
    assert (done === exp_done) else begin
      tests_failed++;
      $error("[TB] FAIL %s done got %b expected %b", tag, done, exp_done);
    end
  endtask

  // Directed sequence of steps with expected values worked out by hand.
  initial begin
    n_rst = 1'b0; clear = 1'b0; load = 1'b0; load_val = 4'd0;
    count_enable = 1'b0; up_down = 1'b1; mode = 2'b00; rollover_val = 4'd5;
    #12;
    check_output("reset", 4'd0, 1'b0, 1'b0);

    // WRAP up, terminal 5
    n_rst = 1'b1; count_enable = 1'b1;
    apply_stimulus(); check_output("wrap_up_1", 4'd1, 1'b0, 1'b0);
    apply_stimulus(); check_output("wrap_up_2", 4'd2, 1'b0, 1'b0);
    apply_stimulus(); check_output("wrap_up_3", 4'd3, 1'b0, 1'b0);
    apply_stimulus(); check_output("wrap_up_4", 4'd4, 1'b0, 1'b0);
    apply_stimulus(); check_output("wrap_up_5", 4'd5, 1'b1, 1'b0);
    apply_stimulus(); check_output("wrap_up_6", 4'd1, 1'b0, 1'b0);
    apply_stimulus(); check_output("wrap_up_7", 4'd2, 1'b0, 1'b0);

    count_enable = 1'b0;
    apply_stimulus(); check_output("hold", 4'd2, 1'b0, 1'b0);

    // WRAP down from 2
    load = 1'b1; load_val = 4'd2; count_enable = 1'b1; up_down = 1'b0;
    apply_stimulus(); check_output("wrap_dn_load", 4'd2, 1'b0, 1'b0);
    load = 1'b0;
    apply_stimulus(); check_output("wrap_dn_1", 4'd1, 1'b0, 1'b0);
    apply_stimulus(); check_output("wrap_dn_2", 4'd5, 1'b1, 1'b0);
    apply_stimulus(); check_output("wrap_dn_3", 4'd4, 1'b0, 1'b0);

    // SATURATE down from 2
    mode = 2'b01; load = 1'b1; load_val = 4'd2;
    apply_stimulus(); check_output("sat_dn_load", 4'd2, 1'b0, 1'b0);
    load = 1'b0;
    apply_stimulus(); check_output("sat_dn_1", 4'd1, 1'b0, 1'b0);
    apply_stimulus(); check_output("sat_dn_2", 4'd0, 1'b0, 1'b0);
    apply_stimulus(); check_output("sat_dn_3", 4'd0, 1'b0, 1'b0);

    // SATURATE up from 3, terminal 4
    rollover_val = 4'd4; up_down = 1'b1; load = 1'b1; load_val = 4'd3;
    apply_stimulus(); check_output("sat_up_load", 4'd3, 1'b0, 1'b0);
    load = 1'b0;
    apply_stimulus(); check_output("sat_up_1", 4'd4, 1'b1, 1'b0);
    apply_stimulus(); check_output("sat_up_2", 4'd4, 1'b1, 1'b0);

    // ONESHOT, terminal 3, counting up even with up_down low
    mode = 2'b10; rollover_val = 4'd3; up_down = 1'b0; clear = 1'b1;
    apply_stimulus(); check_output("os_clear", 4'd0, 1'b0, 1'b0);
    clear = 1'b0;
    apply_stimulus(); check_output("os_1", 4'd1, 1'b0, 1'b0);
    apply_stimulus(); check_output("os_2", 4'd2, 1'b0, 1'b0);
    apply_stimulus(); check_output("os_3", 4'd3, 1'b1, 1'b1);
    apply_stimulus(); check_output("os_4", 4'd3, 1'b1, 1'b1);
    load = 1'b1; load_val = 4'd0;
    apply_stimulus(); check_output("os_load0", 4'd0, 1'b0, 1'b0);
    load = 1'b0;

    // Priority: clear over load over count
    mode = 2'b00; rollover_val = 4'd5; up_down = 1'b1; count_enable = 1'b0;
    load = 1'b1; load_val = 4'd6;
    apply_stimulus(); check_output("prio_load6", 4'd6, 1'b0, 1'b0);
    clear = 1'b1; count_enable = 1'b1;
    apply_stimulus(); check_output("prio_clear", 4'd0, 1'b0, 1'b0);
    clear = 1'b0; load_val = 4'd9;
    apply_stimulus(); check_output("prio_load9", 4'd9, 1'b0, 1'b0);
    load = 1'b0;

    // Leaving ONESHOT while in DONE drops done
    mode = 2'b10; rollover_val = 4'd2; clear = 1'b1;
    apply_stimulus(); check_output("mc_clear", 4'd0, 1'b0, 1'b0);
    clear = 1'b0;
    apply_stimulus(); check_output("mc_1", 4'd1, 1'b0, 1'b0);
    apply_stimulus(); check_output("mc_2", 4'd2, 1'b1, 1'b1);
    mode = 2'b00; count_enable = 1'b0;
    apply_stimulus(); check_output("mc_leave", 4'd2, 1'b1, 1'b0);

    // Asynchronous reset while in DONE at count 4
    mode = 2'b10; rollover_val = 4'd4; clear = 1'b1;
    apply_stimulus(); check_output("rst_clear", 4'd0, 1'b0, 1'b0);
    clear = 1'b0; count_enable = 1'b1;
    apply_stimulus(); check_output("rst_1", 4'd1, 1'b0, 1'b0);
    apply_stimulus(); check_output("rst_2", 4'd2, 1'b0, 1'b0);
    apply_stimulus(); check_output("rst_3", 4'd3, 1'b0, 1'b0);
    apply_stimulus(); check_output("rst_4", 4'd4, 1'b1, 1'b1);
    #2 n_rst = 1'b0;
    #1 check_output("rst_async", 4'd0, 1'b0, 1'b0);
    #3 n_rst = 1'b1;
    apply_stimulus(); check_output("rst_resume", 4'd1, 1'b0, 1'b0);

    // Terminal value of zero freezes counting
    mode = 2'b00; rollover_val = 4'd0;
    apply_stimulus(); check_output("rv0_wrap", 4'd1, 1'b0, 1'b0);
    mode = 2'b01;
    apply_stimulus(); check_output("rv0_sat", 4'd1, 1'b0, 1'b0);

    // Loaded value above the terminal wraps to 1 in WRAP up
    mode = 2'b00; rollover_val = 4'd10; load = 1'b1; load_val = 4'd12;
    apply_stimulus(); check_output("above_load", 4'd12, 1'b0, 1'b0);
    load = 1'b0;
    apply_stimulus(); check_output("above_wrap", 4'd1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/flex_mode_counter.md
FLEX_MODE_COUNTER -- requirements
Module: flex_mode_counter

Interface
REQ-001 The block SHALL have parameter NUM_CNT_BITS, default 4, giving the counter width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port n_rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port clear, input, 1 bit: synchronous clear, highest-priority function input.
REQ-005 The block SHALL have port load, input, 1 bit: synchronous load of load_val.
REQ-006 The block SHALL have port load_val, input, NUM_CNT_BITS bits: value loaded when load is high.
REQ-007 The block SHALL have port count_enable, input, 1 bit: advance the count by one step this cycle.
REQ-008 The block SHALL have port up_down, input, 1 bit: 1 counts up, 0 counts down.
REQ-009 The block SHALL have port mode, input, 2 bits: 00 WRAP, 01 SATURATE, 10 ONESHOT, 11 reserved and treated as WRAP.
REQ-010 The block SHALL have port rollover_val, input, NUM_CNT_BITS bits: terminal count value; sampled every cycle, not latched.
REQ-011 The block SHALL have port count_out, output, NUM_CNT_BITS bits: the registered current count.
REQ-012 The block SHALL have port rollover_flag, output, 1 bit: registered, high exactly while count_out == rollover_val.
REQ-013 The block SHALL have port done, output, 1 bit: registered, high while the ONESHOT state machine is in DONE.

Function
REQ-014 Per-cycle priority SHALL be: clear, then load, then count_enable, then hold.
REQ-015 clear SHALL set count_out to 0 and the state machine to IDLE on the next edge, regardless of other inputs.
REQ-016 load SHALL set count_out to load_val and the state machine to IDLE on the next edge; it SHALL NOT count in that cycle.
REQ-017 With count_enable low and no clear or load, count_out and the state SHALL hold.
REQ-018 WRAP up SHALL go count+1 while count < rollover_val, and go to 1 when count >= rollover_val (the range after the first wrap is 1..rollover_val).
REQ-019 WRAP down SHALL go count-1 while count > 1, and go to rollover_val when count <= 1.
REQ-020 SATURATE up SHALL go count+1 while count < rollover_val, and go to rollover_val (hold) when count >= rollover_val.
REQ-021 SATURATE down SHALL go count-1 while count > 0, and hold at 0 when count == 0.
REQ-022 ONESHOT SHALL ignore up_down and count up only, through the FSM states IDLE, RUN and DONE.
REQ-023 ONESHOT IDLE to RUN SHALL happen on count_enable, and the count SHALL increment in that same cycle.
REQ-024 ONESHOT RUN SHALL increment on count_enable, and SHALL enter DONE on the edge where the new count equals rollover_val.
REQ-025 ONESHOT IDLE with count_enable and count >= rollover_val SHALL go directly to DONE and set the count to rollover_val.
REQ-026 In ONESHOT DONE, count_enable SHALL be ignored; only clear, load or n_rst SHALL leave DONE (to IDLE).
REQ-027 A mode change away from ONESHOT SHALL force the state to IDLE on the next edge; done then SHALL fall.
REQ-028 With rollover_val == 0, count_enable SHALL have no effect on count_out in any mode; clear and load still apply.
REQ-029 rollover_flag SHALL be computed from the next-state count and registered, so it is never combinational from inputs.
REQ-030 All arithmetic SHALL be NUM_CNT_BITS wide and unsigned, with no wrap through 2^NUM_CNT_BITS-1 except as defined above.

Reset
REQ-031 n_rst low SHALL immediately set count_out = 0, rollover_flag = 0, done = 0, and the state to IDLE.
REQ-032 Reset SHALL override all inputs, including mid-count or while in DONE; counting SHALL resume on the first enabled edge after release.

Verification
REQ-033 Reset, then WRAP up with rollover_val = 5 and enable high for 7 cycles SHALL give count 1,2,3,4,5,1,2, with rollover_flag high only while count = 5.
REQ-034 WRAP down from load_val = 2 with rollover_val = 5 SHALL give 1,5,4; SATURATE down from 2 SHALL give 1,0,0; SATURATE up from 3 with rollover_val = 4 SHALL give 4,4.
REQ-035 ONESHOT with rollover_val = 3 and enable held SHALL give 1,2,3,3; done SHALL rise with count = 3 and persist; load_val = 0 SHALL clear done the next cycle.
REQ-036 Simultaneous clear, load and count_enable at count = 6 SHALL give 0; load and count_enable with load_val = 9 SHALL give 9, not 10.
REQ-037 Asserting n_rst mid-edge at count = 4 in DONE SHALL give outputs 0 immediately; after release with enable high, the first edge SHALL give count = 1.
REQ-038 rollover_val = 0 with enable high SHALL hold the count; loading 12 with rollover_val = 10 in WRAP up SHALL give 1 on the next enabled edge.
